// File: rtl/hex_display_ctrl.sv
// Multi-digit active-low 7-segment controller: serial double-dabble BCD conversion (or raw hex),
// leading-zero blanking and overflow dashes. Optional blinking via macro DISP_BLINK_EN.
module hex_display_ctrl #(
   parameter int IN_WIDTH   = 20,
   parameter int NUM_DIGITS = 6,
   parameter int HEX_MODE   = 0,
   parameter int LZ_BLANK   = 1
`ifdef DISP_BLINK_EN
   ,
   parameter int BLINK_DIV  = 25_000_000
`endif
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_i,
   input  logic [IN_WIDTH-1:0]     value_i,
`ifdef DISP_BLINK_EN
   input  logic                    blink_i,
`endif
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    overflow_o,
   output logic [NUM_DIGITS*7-1:0] seg_o
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int EXT_W = (IN_WIDTH > BCD_W) ? IN_WIDTH : BCD_W;
   localparam int CNT_W = $clog2(IN_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_UPDATE
   } state_t;

   state_t                  r_state;
   logic [IN_WIDTH-1:0]     r_shift;
   logic [BCD_W-1:0]        r_bcd;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_ovf_acc;
   logic                    r_overflow;
   logic                    r_busy;
   logic                    r_done;
   logic [NUM_DIGITS*7-1:0] r_seg;

   logic [BCD_W-1:0]        w_bcd_adj;
   logic [EXT_W-1:0]        w_shift_ext;
   logic                    w_hex_ovf;
   logic [BCD_W-1:0]        w_digits;
   logic                    w_show_ovf;
   logic [NUM_DIGITS-1:0]   w_lead_zero;
   logic [NUM_DIGITS*7-1:0] w_seg_next;

   function automatic logic [6:0] f_seg(input logic [3:0] nib);
      logic [6:0] seg;
      seg = 7'b1111111;
      case (nib)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   // Add-3 correction applied to every BCD nibble before each shift
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
         assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? (r_bcd[4*gi +: 4] + 4'd3)
                                                                 : r_bcd[4*gi +: 4];
      end
   endgenerate

   // Hex mode reads the captured value directly, zero-extended to the digit field
   assign w_shift_ext = EXT_W'(r_shift);
   assign w_hex_ovf   = |(w_shift_ext >> BCD_W);
   assign w_digits    = (HEX_MODE != 0) ? w_shift_ext[BCD_W-1:0] : r_bcd;
   assign w_show_ovf  = (HEX_MODE != 0) ? w_hex_ovf : r_ovf_acc;

   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         if (gi == 0 || LZ_BLANK == 0) begin : g_keep
            assign w_lead_zero[gi] = 1'b0;
         end else begin : g_blank
            assign w_lead_zero[gi] = (w_digits[BCD_W-1:4*gi] == '0);
         end
         assign w_seg_next[7*gi +: 7] = w_show_ovf      ? 7'b0111111 :
                                        w_lead_zero[gi] ? 7'b1111111 :
                                                          f_seg(w_digits[4*gi +: 4]);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_ovf_acc  <= 1'b0;
         r_overflow <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_seg      <= '1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (load_i) begin
                  r_shift   <= value_i;
                  r_bcd     <= '0;
                  r_ovf_acc <= 1'b0;
                  r_cnt     <= CNT_W'(IN_WIDTH);
                  r_busy    <= 1'b1;
                  r_state   <= (HEX_MODE != 0) ? S_UPDATE : S_SHIFT;
               end
            end
            S_SHIFT: begin
               // A carry out of the top digit means the value needs more digits than we have
               r_bcd     <= {w_bcd_adj[BCD_W-2:0], r_shift[IN_WIDTH-1]};
               r_ovf_acc <= r_ovf_acc | w_bcd_adj[BCD_W-1];
               r_shift   <= r_shift << 1;
               r_cnt     <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               r_seg      <= w_seg_next;
               r_overflow <= w_show_ovf;
               r_busy     <= 1'b0;
               r_done     <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign overflow_o = r_overflow;

`ifdef DISP_BLINK_EN
   localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BL_W-1:0] r_blink_cnt;
   logic            r_phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (r_blink_cnt == BL_W'(BLINK_DIV - 1)) begin
         r_blink_cnt <= '0;
         r_phase     <= ~r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   assign seg_o = (blink_i && r_phase) ? '1 : r_seg;
`else
   assign seg_o = r_seg;
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: decimal (with and without blanking) and raw-hex instances.
module tb_hex_display_ctrl;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SA = 7'b0001000;
   localparam logic [6:0] SB = 7'b0000011;
   localparam logic [6:0] SC = 7'b1000110;
   localparam logic [6:0] SD = 7'b0100001;
   localparam logic [6:0] SE = 7'b0000110;
   localparam logic [6:0] SF = 7'b0001110;
   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] DA = 7'b0111111;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [19:0] value;
   logic        load_h;
   logic [23:0] value_h;

   logic        busy_a, done_a, ovf_a;
   logic [41:0] seg_a;
   logic        busy_b, done_b, ovf_b;
   logic [41:0] seg_b;
   logic        busy_h, done_h, ovf_h;
   logic [41:0] seg_h;

   int n_vec = 0;
   int n_err = 0;
   int bc;

   hex_display_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load),
      .value_i    (value),
`ifdef DISP_BLINK_EN
      .blink_i    (1'b0),
`endif
      .busy_o     (busy_a),
      .done_o     (done_a),
      .overflow_o (ovf_a),
      .seg_o      (seg_a)
   );

   hex_display_ctrl #(.LZ_BLANK(0)) dut_nlz (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load),
      .value_i    (value),
`ifdef DISP_BLINK_EN
      .blink_i    (1'b0),
`endif
      .busy_o     (busy_b),
      .done_o     (done_b),
      .overflow_o (ovf_b),
      .seg_o      (seg_b)
   );

   hex_display_ctrl #(.HEX_MODE(1), .IN_WIDTH(24)) dut_hex (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load_h),
      .value_i    (value_h),
`ifdef DISP_BLINK_EN
      .blink_i    (1'b0),
`endif
      .busy_o     (busy_h),
      .done_o     (done_h),
      .overflow_o (ovf_h),
      .seg_o      (seg_h)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the load edge
   task automatic start(input logic [19:0] v);
      load  = 1'b1;
      value = v;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      for (int i = 0; i < 100 && !done_a; i++) begin
         if (busy_a) cycles++;
         @(negedge clk);
      end
      chk("done_seen", {63'd0, done_a}, 64'd1);
      $display("load value=%0d busy_cycles=%0d seg=%h ovf=%0b", value, cycles, seg_a, ovf_a);
   endtask

   initial begin
      rst_n   = 1'b0;
      load    = 1'b0;
      value   = '0;
      load_h  = 1'b0;
      value_h = '0;
      repeat (3) @(negedge clk);
      chk("rst_seg",  seg_a, {42{1'b1}});
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_ovf",  ovf_a, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_seg",  seg_a, {42{1'b1}});
      chk("idle_busy", busy_a, 0);

      start(20'd123456);
      wait_done(bc);
      chk("t2_busy_cycles", bc, 21);
      chk("t2_seg", seg_a, {S1, S2, S3, S4, S5, S6});
      chk("t2_ovf", ovf_a, 0);
      @(negedge clk);
      chk("t2_done_width", done_a, 0);

      start(20'd42);
      wait_done(bc);
      chk("t3_seg42", seg_a, {BL, BL, BL, BL, S4, S2});
      chk("t3_seg42_nlz", seg_b, {S0, S0, S0, S0, S4, S2});
      start(20'd0);
      chk("t3_accept_on_done", busy_a, 1);
      wait_done(bc);
      chk("t3_seg0", seg_a, {BL, BL, BL, BL, BL, S0});
      @(negedge clk);

      start(20'd1000000);
      wait_done(bc);
      chk("t4_ovf", ovf_a, 1);
      chk("t4_seg_dash", seg_a, {DA, DA, DA, DA, DA, DA});
      @(negedge clk);
      start(20'd7);
      wait_done(bc);
      chk("t4_ovf_clear", ovf_a, 0);
      chk("t4_seg7", seg_a, {BL, BL, BL, BL, BL, S7});
      @(negedge clk);

      start(20'd999999);
      repeat (8) @(negedge clk);
      load  = 1'b1;
      value = 20'd5;
      @(negedge clk);
      load  = 1'b0;
      wait_done(bc);
      chk("t5_seg999999", seg_a, {S9, S9, S9, S9, S9, S9});
      chk("t5_ovf", ovf_a, 0);
      repeat (30) @(negedge clk);
      chk("t5_no_requeue_busy", busy_a, 0);
      chk("t5_hold_seg", seg_a, {S9, S9, S9, S9, S9, S9});

      start(20'd123456);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", busy_a, 0);
      chk("t5_rst_seg", seg_a, {42{1'b1}});
      chk("t5_rst_done", done_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_post_rst_busy", busy_a, 0);
      chk("t5_post_rst_seg", seg_a, {42{1'b1}});

      load_h  = 1'b1;
      value_h = 24'hABCDEF;
      @(negedge clk);
      load_h  = 1'b0;
      chk("t6_busy", busy_h, 1);
      chk("t6_done_early", done_h, 0);
      chk("t6_seg_before", seg_h, {42{1'b1}});
      @(negedge clk);
      chk("t6_busy_end", busy_h, 0);
      chk("t6_done", done_h, 1);
      chk("t6_seg", seg_h, {SA, SB, SC, SD, SE, SF});
      chk("t6_ovf", ovf_h, 0);
      $display("hex load value=%h seg=%h ovf=%0b", value_h, seg_h, ovf_h);
      @(negedge clk);
      chk("t6_done_width", done_h, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
